video_bus_arbiter: RTL and testbench

//  Owns the single video-memory port (VRAM $8000-$9FFF, OAM $FE00-$FE9F, plus the DMA source space) and

---
 rtl/video_bus_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_video_bus_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_bus_arbiter.sv
// Video-memory port arbiter: shares VRAM/OAM/DMA-source access between DMA, PPU and CPU,
// applies PPU-mode and DMA lockouts, and runs the OAM DMA copy engine behind $FF46.
module video_bus_arbiter #(
   parameter int         DMA_LEN         = 160,
   parameter int         DMA_START_DELAY = 1,
   parameter logic [7:0] OPEN_BUS        = 8'hFF
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        mclk_in,
   input  logic        lcd_en_in,
   input  logic [1:0]  ppu_mode_in,
   input  logic        cpu_req_in,
   input  logic        cpu_we_in,
   input  logic [15:0] cpu_addr_in,
   input  logic [7:0]  cpu_wdata_in,
   output logic        cpu_gnt_out,
   output logic        cpu_rvalid_out,
   output logic [7:0]  cpu_rdata_out,
   input  logic        ppu_req_in,
   input  logic [15:0] ppu_addr_in,
   output logic        ppu_gnt_out,
   output logic        ppu_rvalid_out,
   output logic [7:0]  ppu_rdata_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [15:0] mem_addr_out,
   output logic [7:0]  mem_wdata_out,
   input  logic [7:0]  mem_rdata_in,
   output logic        dma_active_out
);

   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_READ, S_LATCH, S_WRITE, S_WAIT} dma_state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_PPU} rd_tag_t;

   localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
   localparam logic [7:0] DLY_LAST  = 8'(DMA_START_DELAY - 1);
   localparam dma_state_t START_ST  = (DMA_START_DELAY == 0) ? S_READ : S_DELAY;

   dma_state_t state_q;
   rd_tag_t    tag_q;
   logic [7:0] idx_q, src_q, byte_q, dly_q, cpu_ldata_q;
   logic       pend_q, dma_active_q, cpu_rvalid_q, ppu_rvalid_q;

   logic       cpu_is_dma_reg, cpu_in_oam, cpu_in_vram, cpu_in_hram;
   logic       cpu_mode_lock, cpu_dma_lock, cpu_local, cpu_mem, cpu_ff46_wr;
   logic       ppu_in_oam, ppu_blocked, ppu_mem, dma_bus;
   logic [7:0] src_eff;

   assign cpu_is_dma_reg = (cpu_addr_in == 16'hFF46);
   assign cpu_in_oam     = (cpu_addr_in >= 16'hFE00) && (cpu_addr_in <= 16'hFE9F);
   assign cpu_in_vram    = (cpu_addr_in[15:13] == 3'b100);
   assign cpu_in_hram    = (cpu_addr_in >= 16'hFF80) && (cpu_addr_in <= 16'hFFFE);
   assign cpu_mode_lock  = lcd_en_in && (((ppu_mode_in == 2'd2) && cpu_in_oam) ||
                                         ((ppu_mode_in == 2'd3) && (cpu_in_oam || cpu_in_vram)));
   assign cpu_dma_lock   = dma_active_q && !cpu_in_hram;
   // Locally answered accesses are granted at once and never touch the memory port.
   assign cpu_local      = cpu_is_dma_reg || cpu_mode_lock || cpu_dma_lock;

   assign ppu_in_oam     = (ppu_addr_in >= 16'hFE00) && (ppu_addr_in <= 16'hFE9F);
   assign ppu_blocked    = dma_active_q && ppu_in_oam;
   assign dma_bus        = (state_q == S_READ) || (state_q == S_WRITE);

   assign ppu_mem        = ppu_req_in && !ppu_blocked && !dma_bus;
   assign ppu_gnt_out    = ppu_req_in && (ppu_blocked || !dma_bus);
   assign cpu_mem        = cpu_req_in && !cpu_local && !dma_bus && !(ppu_req_in && !ppu_blocked);
   assign cpu_gnt_out    = cpu_req_in && (cpu_local || cpu_mem);
   assign cpu_ff46_wr    = cpu_req_in && cpu_is_dma_reg && cpu_we_in;

   // Sources above $DF would hit echo/IO space; fold them down into WRAM.
   assign src_eff        = (src_q > 8'hDF) ? (src_q - 8'h20) : src_q;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      mem_req_out   = 1'b0;
      mem_we_out    = 1'b0;
      mem_addr_out  = 16'h0000;
      mem_wdata_out = 8'h00;
      if (dma_bus) begin
         mem_req_out = 1'b1;
         if (state_q == S_WRITE) begin
            mem_we_out    = 1'b1;
            mem_addr_out  = {8'hFE, idx_q};
            mem_wdata_out = byte_q;
         end else begin
            mem_addr_out  = {src_eff, idx_q};
         end
      end else if (ppu_mem) begin
         mem_req_out  = 1'b1;
         mem_addr_out = ppu_addr_in;
      end else if (cpu_mem) begin
         mem_req_out   = 1'b1;
         mem_we_out    = cpu_we_in;
         mem_addr_out  = cpu_addr_in;
         mem_wdata_out = cpu_wdata_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         tag_q        <= TAG_NONE;
         cpu_rvalid_q <= 1'b0;
         ppu_rvalid_q <= 1'b0;
         cpu_ldata_q  <= 8'h00;
      end else begin
         cpu_rvalid_q <= cpu_gnt_out && !cpu_we_in;
         ppu_rvalid_q <= ppu_gnt_out;
         cpu_ldata_q  <= cpu_is_dma_reg ? src_q : OPEN_BUS;
         if (ppu_mem)
            tag_q <= TAG_PPU;
         else if (cpu_mem && !cpu_we_in)
            tag_q <= TAG_CPU;
         else
            tag_q <= TAG_NONE;
      end
   end

   assign cpu_rvalid_out = cpu_rvalid_q;
   assign cpu_rdata_out  = !cpu_rvalid_q ? 8'h00 :
                           (tag_q == TAG_CPU) ? mem_rdata_in : cpu_ldata_q;
   assign ppu_rvalid_out = ppu_rvalid_q;
   assign ppu_rdata_out  = !ppu_rvalid_q ? 8'h00 :
                           (tag_q == TAG_PPU) ? mem_rdata_in : OPEN_BUS;
   assign dma_active_out = dma_active_q;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         idx_q        <= 8'h00;
         src_q        <= 8'hFF;
         byte_q       <= 8'h00;
         dly_q        <= 8'h00;
         pend_q       <= 1'b0;
         dma_active_q <= 1'b0;
      end else begin
         case (state_q)
            S_DELAY: begin
               if (mclk_in) begin
                  if (dly_q == DLY_LAST) begin
                     dly_q   <= 8'h00;
                     state_q <= S_READ;
                  end else begin
                     dly_q <= dly_q + 8'h01;
                  end
               end
            end
            S_READ: begin
               state_q <= S_LATCH;
               if (mclk_in) pend_q <= 1'b1;
            end
            S_LATCH: begin
               byte_q  <= mem_rdata_in;
               state_q <= S_WRITE;
               if (mclk_in) pend_q <= 1'b1;
            end
            S_WRITE: begin
               if (idx_q == LAST_IDX) begin
                  state_q      <= S_IDLE;
                  dma_active_q <= 1'b0;
                  pend_q       <= 1'b0;
               end else begin
                  idx_q   <= idx_q + 8'h01;
                  state_q <= S_WAIT;
                  if (mclk_in) pend_q <= 1'b1;
               end
            end
            S_WAIT: begin
               if (mclk_in || pend_q) begin
                  pend_q  <= 1'b0;
                  state_q <= S_READ;
               end
            end
            default: ;
         endcase
         // A $FF46 write overrides whatever the FSM chose; a D_WRITE on the bus this cycle still lands.
         if (cpu_ff46_wr) begin
            src_q        <= cpu_wdata_in;
            idx_q        <= 8'h00;
            dly_q        <= 8'h00;
            pend_q       <= 1'b0;
            state_q      <= START_ST;
            dma_active_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_video_bus_arbiter.sv
// Scoreboard bench for video_bus_arbiter: a behavioural memory, queued expected read data and
// memory writes, and a negedge monitor that pops and compares whenever the DUT presents them.
module tb_video_bus_arbiter;

   logic        clk_in = 1'b0, rst_in = 1'b1, mclk_in = 1'b0;
   logic        lcd_en_in = 1'b0;
   logic [1:0]  ppu_mode_in = 2'd0;
   logic        cpu_req_in = 1'b0, cpu_we_in = 1'b0;
   logic [15:0] cpu_addr_in = 16'h0000;
   logic [7:0]  cpu_wdata_in = 8'h00;
   logic        ppu_req_in = 1'b0;
   logic [15:0] ppu_addr_in = 16'h0000;
   logic        cpu_gnt_out, cpu_rvalid_out, ppu_gnt_out, ppu_rvalid_out;
   logic [7:0]  cpu_rdata_out, ppu_rdata_out;
   logic        mem_req_out, mem_we_out, dma_active_out;
   logic [15:0] mem_addr_out;
   logic [7:0]  mem_wdata_out;
   logic [7:0]  mem_rdata_in = 8'h00;

   video_bus_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .mclk_in(mclk_in),
      .lcd_en_in(lcd_en_in), .ppu_mode_in(ppu_mode_in),
      .cpu_req_in(cpu_req_in), .cpu_we_in(cpu_we_in), .cpu_addr_in(cpu_addr_in),
      .cpu_wdata_in(cpu_wdata_in), .cpu_gnt_out(cpu_gnt_out),
      .cpu_rvalid_out(cpu_rvalid_out), .cpu_rdata_out(cpu_rdata_out),
      .ppu_req_in(ppu_req_in), .ppu_addr_in(ppu_addr_in), .ppu_gnt_out(ppu_gnt_out),
      .ppu_rvalid_out(ppu_rvalid_out), .ppu_rdata_out(ppu_rdata_out),
      .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_wdata_out(mem_wdata_out), .mem_rdata_in(mem_rdata_in),
      .dma_active_out(dma_active_out)
   );

   always #5 clk_in = ~clk_in;

   int unsigned cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // M-cycle strobe: one clk wide, every 4 clocks.
   logic [1:0] mph = 2'd0;
   always @(posedge clk_in) begin
      #1;
      mph     = mph + 2'd1;
      mclk_in = (mph == 2'd0);
   end

   logic [7:0] mem [0:65535];
   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   always @(posedge clk_in) begin
      if (mem_req_out) begin
         if (mem_we_out) mem[mem_addr_out] <= mem_wdata_out;
         else            mem_rdata_in      <= mem[mem_addr_out];
      end
   end

   int n_vec = 0, n_fail = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   logic [7:0]  cpu_q[$];
   logic [7:0]  ppu_q[$];
   logic [23:0] wr_q[$];

   always @(negedge clk_in) begin
      if (cpu_rvalid_out) begin
         if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
         else check("cpu_rdata", {24'h0, cpu_rdata_out}, {24'h0, cpu_q.pop_front()});
      end
      if (ppu_rvalid_out) begin
         if (ppu_q.size() == 0) check("ppu_rvalid_unexpected", 1, 0);
         else check("ppu_rdata", {24'h0, ppu_rdata_out}, {24'h0, ppu_q.pop_front()});
      end
      if (mem_req_out && mem_we_out) begin
         if (wr_q.size() == 0) check("mem_wr_unexpected", {8'h0, mem_addr_out, mem_wdata_out}, 0);
         else check("mem_wr", {8'h0, mem_addr_out, mem_wdata_out}, {8'h0, wr_q.pop_front()});
      end
   end

   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd, input logic exp_wr,
                             output int unsigned gnt_cyc, output logic mem_seen);
      int n;
      if (!we) cpu_q.push_back(exp_rd);
      if (we && exp_wr) wr_q.push_back({addr, wdata});
      @(posedge clk_in); #1;
      cpu_req_in = 1'b1; cpu_we_in = we; cpu_addr_in = addr; cpu_wdata_in = wdata;
      gnt_cyc = 0; mem_seen = 1'b0;
      for (n = 0; n < 50; n++) begin
         @(negedge clk_in);
         if (cpu_gnt_out) break;
      end
      if (n == 50) check("cpu_gnt_timeout", 0, 1);
      gnt_cyc  = cyc;
      mem_seen = mem_req_out;
      @(posedge clk_in); #1;
      cpu_req_in = 1'b0; cpu_we_in = 1'b0;
   endtask

   task automatic ppu_access(input logic [15:0] addr, input logic [7:0] exp_rd,
                             output int unsigned gnt_cyc);
      int n;
      ppu_q.push_back(exp_rd);
      @(posedge clk_in); #1;
      ppu_req_in = 1'b1; ppu_addr_in = addr;
      gnt_cyc = 0;
      for (n = 0; n < 50; n++) begin
         @(negedge clk_in);
         if (ppu_gnt_out) break;
      end
      if (n == 50) check("ppu_gnt_timeout", 0, 1);
      gnt_cyc = cyc;
      @(posedge clk_in); #1;
      ppu_req_in = 1'b0;
   endtask

   task automatic push_dma(input logic [15:0] src_base, input int count);
      for (int i = 0; i < count; i++)
         wr_q.push_back({16'hFE00 + 16'(i), init_val(src_base + 16'(i))});
   endtask

   task automatic wait_dma_done(input string name, output int active_cycles);
      active_cycles = 0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk_in);
         if (!dma_active_out) break;
         active_cycles++;
      end
      if (dma_active_out) check({name, "_timeout"}, 1, 0);
   endtask

   int unsigned gc, gp;
   logic        ms;
   int          act_cyc, bad;

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = init_val(16'(a));
      repeat (3) @(posedge clk_in);
      check("reset_outputs",
            {cpu_gnt_out, cpu_rvalid_out, cpu_rdata_out, ppu_gnt_out, ppu_rvalid_out,
             ppu_rdata_out, mem_req_out, mem_we_out, mem_addr_out != 0, mem_wdata_out, dma_active_out}, 0);
      @(posedge clk_in); #1; rst_in = 1'b0;
      cpu_access(1'b0, 16'hFF46, 8'h00, 8'hFF, 1'b0, gc, ms);
      check("ff46_reset_memreq", ms, 0);

      // Mode lockouts
      lcd_en_in = 1'b1; ppu_mode_in = 2'd3;
      cpu_access(1'b0, 16'h8010, 8'h00, 8'hFF, 1'b0, gc, ms);
      check("m3_vram_memreq", ms, 0);
      cpu_access(1'b1, 16'h8020, 8'h55, 8'h00, 1'b0, gc, ms);
      check("m3_wr_memreq", ms, 0);
      ppu_mode_in = 2'd2;
      cpu_access(1'b0, 16'hFE9F, 8'h00, 8'hFF, 1'b0, gc, ms);
      cpu_access(1'b0, 16'hFEA0, 8'h00, init_val(16'hFEA0), 1'b0, gc, ms);
      check("m2_fea0_memreq", ms, 1);
      cpu_access(1'b0, 16'h8010, 8'h00, init_val(16'h8010), 1'b0, gc, ms);
      lcd_en_in = 1'b0; ppu_mode_in = 2'd3;
      cpu_access(1'b0, 16'hFE10, 8'h00, init_val(16'hFE10), 1'b0, gc, ms);
      lcd_en_in = 1'b1; ppu_mode_in = 2'd0;
      cpu_access(1'b0, 16'h8020, 8'h00, init_val(16'h8020), 1'b0, gc, ms);
      cpu_access(1'b1, 16'hFE05, 8'h3C, 8'h00, 1'b1, gc, ms);
      check("m0_wr_memreq", ms, 1);
      cpu_access(1'b0, 16'hFE05, 8'h00, 8'h3C, 1'b0, gc, ms);

      // Full DMA from $C100
      push_dma(16'hC100, 160);
      cpu_access(1'b1, 16'hFF46, 8'hC1, 8'h00, 1'b0, gc, ms);
      wait_dma_done("dma1", act_cyc);
      check("dma1_len_ok", (act_cyc >= 640 && act_cyc <= 643), 1);
      check("dma1_writes_left", wr_q.size(), 0);
      bad = 0;
      for (int i = 0; i < 160; i++)
         if (mem[16'hFE00 + 16'(i)] !== init_val(16'hC100 + 16'(i))) bad++;
      check("oam_copy", bad, 0);

      // Accesses during DMA
      push_dma(16'hC100, 160);
      cpu_access(1'b1, 16'hFF46, 8'hC1, 8'h00, 1'b0, gc, ms);
      cpu_access(1'b0, 16'hFF90, 8'h00, init_val(16'hFF90), 1'b0, gc, ms);
      cpu_access(1'b0, 16'hC000, 8'h00, 8'hFF, 1'b0, gc, ms);
      cpu_access(1'b1, 16'hC000, 8'h77, 8'h00, 1'b0, gc, ms);
      ppu_access(16'hFE00, 8'hFF, gp);
      cpu_access(1'b0, 16'hFF46, 8'h00, 8'hC1, 1'b0, gc, ms);
      check("dma2_active_mid", dma_active_out, 1);
      wait_dma_done("dma2", act_cyc);
      check("dma2_writes_left", wr_q.size(), 0);
      check("c000_not_written", mem[16'hC000], init_val(16'hC000));

      // PPU beats CPU on a simultaneous request
      fork
         cpu_access(1'b0, 16'h8000, 8'h00, init_val(16'h8000), 1'b0, gc, ms);
         ppu_access(16'h8000, init_val(16'h8000), gp);
      join
      check("ppu_first_gnt_order", gc - gp, 1);

      // Reset mid-DMA from $E5 (folds to $C500) after byte 40 is written
      push_dma(16'hC500, 41);
      cpu_access(1'b1, 16'hFF46, 8'hE5, 8'h00, 1'b0, gc, ms);
      for (int n = 0; n < 1000 && wr_q.size() != 0; n++) @(negedge clk_in);
      check("dma3_reached_40", wr_q.size(), 0);
      @(posedge clk_in); #1; rst_in = 1'b1;
      #1 check("rst_dma_active", dma_active_out, 0);
      repeat (3) @(posedge clk_in);
      #1 rst_in = 1'b0;
      repeat (40) @(posedge clk_in);
      cpu_access(1'b0, 16'hFF46, 8'h00, 8'hFF, 1'b0, gc, ms);
      repeat (3) @(posedge clk_in);
      check("queues_empty", cpu_q.size() + ppu_q.size() + wr_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
